// File: rtl/sponge_absorb.sv
// sponge_absorb: absorbs 64-bit message lanes into the Keccak state memory.
// Define SPONGE_PAD_EN to add SHA-3 pad10*1 padding with domain byte 0x06.
module sponge_absorb #(
    parameter int RATE_LANES  = 17,
    parameter int STATE_LANES = 25
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [63:0] msg_data,
    input  logic        msg_valid,
    input  logic        msg_last,
    input  logic [3:0]  msg_bytes,
    output logic        msg_ready,
    output logic [4:0]  mem_adr,
    output logic [63:0] mem_in,
    input  logic [63:0] mem_out,
    output logic        mem_r,
    output logic        mem_w,
    output logic        perm_start,
    input  logic        perm_done,
    output logic        done
);

    localparam logic [3:0] S_IDLE   = 4'd0;
    localparam logic [3:0] S_CLEAR  = 4'd1;
    localparam logic [3:0] S_WORD   = 4'd2;
    localparam logic [3:0] S_READ   = 4'd3;
    localparam logic [3:0] S_XOR    = 4'd4;
    localparam logic [3:0] S_PSTART = 4'd5;
    localparam logic [3:0] S_PWAIT  = 4'd6;
    localparam logic [3:0] S_DONE   = 4'd7;

    localparam logic [4:0] RL       = 5'(RATE_LANES);
    localparam logic [4:0] LAST_ADR = 5'(STATE_LANES - 1);

    logic [3:0]  state;
    logic [4:0]  lane;
    logic [4:0]  nxt_lane;
    logic [63:0] word;
    logic [63:0] lane_word;
    logic        last_seen;
    logic        final_blk;

`ifdef SPONGE_PAD_EN
    localparam logic [3:0]  S_PAD   = 4'd8;
    localparam logic [4:0]  RL_LAST = 5'(RATE_LANES - 1);
    localparam logic [63:0] END_BIT = {8'h80, 56'h0};

    logic        need06;
    logic        need80;
    logic [3:0]  kb;
    logic [5:0]  sh;
    logic [63:0] keep;
    logic [63:0] pad_word;

    // kb[3] set means a full lane: the domain byte spills to the next lane
    assign kb   = (msg_bytes > 4'd8) ? 4'd8 : msg_bytes;
    assign sh   = {kb[2:0], 3'b000};
    assign keep = kb[3] ? '1 : ((64'd1 << sh) - 64'd1);

    always_comb begin
        lane_word = msg_data;
        if (msg_last) begin
            lane_word = msg_data & keep;
            if (!kb[3]) begin
                lane_word = lane_word ^ (64'h06 << sh);
                if (lane == RL_LAST)
                    lane_word = lane_word ^ END_BIT;
            end
        end
    end

    always_comb begin
        pad_word = '0;
        if (need06)
            pad_word = pad_word | 64'h06;
        if (need80 && lane == RL_LAST)
            pad_word = pad_word | END_BIT;
    end

    assign final_blk = last_seen && !need06 && !need80;
`else
    logic unused_bytes;

    assign unused_bytes = ^msg_bytes;
    assign lane_word    = msg_data;
    assign final_blk    = last_seen;
`endif

    assign nxt_lane   = lane + 5'd1;
    assign msg_ready  = (state == S_WORD);
    assign mem_r      = (state == S_READ);
    assign mem_w      = (state == S_CLEAR) || (state == S_XOR);
    assign mem_adr    = (mem_r || mem_w) ? lane : 5'd0;
    assign mem_in     = (state == S_XOR) ? (mem_out ^ word) : '0;
    assign perm_start = (state == S_PSTART);
    assign done       = (state == S_DONE);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            lane      <= '0;
            word      <= '0;
            last_seen <= 1'b0;
`ifdef SPONGE_PAD_EN
            need06    <= 1'b0;
            need80    <= 1'b0;
`endif
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        state     <= S_CLEAR;
                        lane      <= '0;
                        last_seen <= 1'b0;
`ifdef SPONGE_PAD_EN
                        need06    <= 1'b0;
                        need80    <= 1'b0;
`endif
                    end
                end
                S_CLEAR: begin
                    if (lane == LAST_ADR) begin
                        lane  <= '0;
                        state <= S_WORD;
                    end else begin
                        lane <= nxt_lane;
                    end
                end
                S_WORD: begin
                    if (msg_valid) begin
                        word      <= lane_word;
                        last_seen <= msg_last;
`ifdef SPONGE_PAD_EN
                        if (msg_last) begin
                            need06 <= kb[3];
                            need80 <= kb[3] || (lane != RL_LAST);
                        end
`endif
                        state <= S_READ;
                    end
                end
                S_READ: state <= S_XOR;
                S_XOR: begin
                    lane <= nxt_lane;
                    if (nxt_lane == RL || final_blk)
                        state <= S_PSTART;
`ifdef SPONGE_PAD_EN
                    else if (last_seen)
                        state <= S_PAD;
`endif
                    else
                        state <= S_WORD;
                end
`ifdef SPONGE_PAD_EN
                // zero pad lanes cost one cycle and no memory access
                S_PAD: begin
                    if (pad_word != '0) begin
                        word   <= pad_word;
                        need06 <= 1'b0;
                        if (lane == RL_LAST)
                            need80 <= 1'b0;
                        state  <= S_READ;
                    end else begin
                        lane <= RL_LAST;
                    end
                end
`endif
                S_PSTART: state <= S_PWAIT;
                S_PWAIT: begin
                    if (perm_done) begin
                        if (final_blk) begin
                            state <= S_DONE;
                        end else begin
                            lane <= '0;
`ifdef SPONGE_PAD_EN
                            state <= last_seen ? S_PAD : S_WORD;
`else
                            state <= S_WORD;
`endif
                        end
                    end
                end
                S_DONE: state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/sponge_absorb.md
Name: sponge_absorb

Overview:
- Absorb stage placed directly upstream of the Keccak permutation block.
- Accepts message lanes over a valid/ready stream, zeroes the state memory at message start, and XORs each lane into the state through the memory's 64-bit lane port.
- After each full rate block it pulses `perm_start` to the permutation block and waits for `perm_done`.
- Asserts `done` after the final block has been permuted.

Parameters:
- `RATE_LANES`, 17, number of 64-bit lanes per rate block (17 = SHA3-256). Legal range 1..24.
- `STATE_LANES`, 25, total lanes cleared at message start.

Ports:
- `clock` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `start` in 1: one-cycle pulse that begins a new message. Ignored unless in IDLE.
- `msg_data` in [0:63]: message lane. Byte k occupies bits 8k..8k+7; LSB-first within the byte (bit 8k+j = bit j of byte k).
- `msg_valid` in 1: `msg_data` is valid.
- `msg_last` in 1: this lane is the final message lane.
- `msg_bytes` in 4: valid bytes in the last lane, 0..8. Sampled only with `msg_last`.
- `msg_ready` out 1: lane accepted when `msg_valid` and `msg_ready` are both high on a clock edge.
- `mem_adr` out 5: lane address 0..24.
- `mem_in` out [0:63]: write data to memory.
- `mem_out` in [0:63]: read data from memory. Valid one cycle after `mem_r`.
- `mem_r` out 1: read strobe.
- `mem_w` out 1: write strobe.
- `perm_start` out 1: one-cycle pulse to the permutation block.
- `perm_done` in 1: permutation finished. Sampled only in PWAIT.
- `done` out 1: one-cycle pulse when the message has been fully absorbed and permuted.

Behaviour:
- Reset: state IDLE; all outputs 0; lane counter 0; `last_seen` 0. Reset mid-operation aborts immediately; memory contents are undefined afterwards.
- CLEAR (entered on `start`): `mem_w`=1, `mem_in`=0, `mem_adr`=0..24, one lane per cycle, 25 cycles, then WORD.
- WORD: `msg_ready`=1. On handshake, register the lane into `word`. With PAD_EN, mask and pad it (see Optional Feature). Go to READ.
- READ: `mem_r`=1, `mem_adr`=lane, one cycle. Then XOR.
- XOR: `mem_w`=1, `mem_in`=`mem_out` ^ `word`, same address. Then increment lane.
- Block end: when lane reaches `RATE_LANES`, go to PSTART.
- Early last lane: if `msg_last` was accepted and lane < `RATE_LANES`, go to PAD. Without PAD_EN, go directly to PSTART; the remaining lanes are not written.
- Throughput: one lane per 3 cycles; `msg_ready` is 0 outside WORD.
- PSTART: `perm_start`=1 for exactly one cycle. Then PWAIT.
- PWAIT: hold until `perm_done`=1.
  - If the final block is finished: pulse `done` for one cycle, then IDLE.
  - Otherwise: lane=0, then WORD.
- `start` is ignored while busy. `msg_valid` is ignored outside WORD; no lane is accepted or lost.
- `mem_r` and `mem_w` are never high in the same cycle.
- Address never exceeds 24.

Optional Feature:
- Macro: `SPONGE_PAD_EN`.
- Defined — SHA-3 pad10*1 with domain byte 0x06:
  - On the last lane with k = `msg_bytes`: bytes k..7 are zeroed. If k<8, byte k ^= 0x06.
  - If k=8, the 0x06 goes into byte 0 of the next lane. If that lane would be index `RATE_LANES`, a new block is started: lane 0 gets 0x06 and the old block is permuted first.
  - PAD state generates pad lanes via READ/XOR. Lanes whose pad value is zero are skipped (no memory access).
  - Lane `RATE_LANES`-1 byte 7 ^= 0x80. If 0x06 lands in that same byte, the byte becomes 0x86.
- Not defined: `msg_bytes` is ignored and the lane is XORed unmodified. The block containing `msg_last` is treated as final; lanes after it are skipped.

Test Plan:
- Reset during CLEAR at cycle 10, then release → all outputs 0, IDLE; a new `start` performs a full 25-lane clear.
- `start`, one lane 0x0000000000636261 ("abc"), `msg_last`, `msg_bytes`=3, PAD_EN → lane0 = 0x0000000006636261, lane16 = 0x8000000000000000, other lanes 0; one `perm_start`, then `done` 1 cycle after `perm_done`.
- PAD_EN, 17 full lanes with `msg_last` on lane 16, `msg_bytes`=8 → two `perm_start` pulses; second block: lane0 ^= 0x06, lane16 ^= 0x8000000000000000; `done` only after the second `perm_done`.
- PAD_EN, `RATE_LANES`=1, empty message (`msg_bytes`=0) → lane0 = 0x8000000000000006.
- `msg_valid` held low for 20 cycles mid-block, `perm_done` delayed 100 cycles → no spurious `mem_w`; `perm_start` asserted exactly once per block.
- No PAD_EN, 34 lanes of 0xFFFFFFFFFFFFFFFF, `msg_last` on lane 33 → each block XORs all-ones into lanes 0..16; lanes 17..24 are never written after CLEAR; two permutations, then `done`.
